flame_sequencer: RTL and testbench
==================================

# flame_sequencer

Sequences one bomb explosion for the flame sprite renderer. It latches the bomb position on a detonation pulse and steps through the 5 flame sprites (grow, hold, shrink) at video-frame rate. It drives the renderer's `flame_centerX`, `flame_centerY` and `sprite_num` inputs and parks the sprite off-screen when idle, so the renderer outputs the transparency code 137.

## Interface
Parameters:
- `FRAMES_PER_SPRITE`, 4: `frame_tick` pulses per sprite step (≥1)
- `HOLD_STEPS`, 2: steps spent on sprite 4 between grow and shrink (≥1)
- `HACTIVE`, 800: active width in pixels
- `VACTIVE`, 600: active height in pixels

Ports:
- `clk`  in  1  pixel clock
- `reset_n`  in  1  asynchronous, active-low reset
- `frame_tick`  in  1  one-cycle pulse per video frame (start of vertical blanking)
- `detonate`  in  1  one-cycle pulse; start an explosion
- `bomb_X`  in  11 signed  sprite top-left X, sampled on `detonate`
- `bomb_Y`  in  11 signed  sprite top-left Y, sampled on `detonate`
- `flame_centerX`  out  11 signed  to renderer
- `flame_centerY`  out  11 signed  to renderer
- `sprite_num`  out  3  sprite index 0..4, to renderer
- `flame_active`  out  1  explosion in progress
- `done`  out  1  one-cycle pulse at end of explosion

Clock and reset: one clock (`clk`). Reset is asynchronous and active-low (`reset_n`).

## Operation
States: IDLE, GROW, HOLD, SHRINK.

- **IDLE.** `flame_active`=0, `sprite_num`=0. `flame_centerX`=`flame_centerY`=-64, which puts the sprite off-screen.
- **IDLE → GROW** on `detonate`:
  - X is latched clamped to [0, HACTIVE-32].
  - Y is latched clamped to [0, VACTIVE-32].
  - Clamping uses a signed compare, so negative inputs become 0.
  - `sprite_num`=0; the frame counter and step counter are cleared.
- **Step timing.**
  - The frame counter (0..FRAMES_PER_SPRITE-1) increments on each `frame_tick` outside IDLE.
  - A step ends on the `frame_tick` at which the counter equals FRAMES_PER_SPRITE-1; the counter then wraps to 0.
- **GROW.** Each step end increments `sprite_num`. When it reaches 4, go to HOLD with the hold counter at 0.
- **HOLD.** `sprite_num`=4. Each step end increments the hold counter. At step end with the hold counter at HOLD_STEPS-1, go to SHRINK with `sprite_num`=3.
- **SHRINK.** Each step end decrements `sprite_num`. At step end with `sprite_num`=0:
  - go to IDLE;
  - pulse `done` for one cycle;
  - restore the off-screen position.
- **Sequence.** The sprite sequence is 0,1,2,3,[4×HOLD_STEPS],3,2,1,0. The explosion lasts (8+HOLD_STEPS)×FRAMES_PER_SPRITE frame ticks.
- **Boundary conditions:**
  - `detonate` outside IDLE is ignored; no queuing.
  - `detonate` in the same cycle as the final step end is ignored, because the FSM is not yet in IDLE.
  - `frame_tick` in the same cycle as `detonate` while IDLE is not counted.
  - `frame_tick` is ignored in IDLE.
  - `bomb_X`/`bomb_Y` changes after latching have no effect.
  - `reset_n` low mid-explosion returns immediately to IDLE outputs; no `done` pulse.

## Timing
- All outputs are registered.
- Reset values:
  - `flame_centerX`=-64, `flame_centerY`=-64
  - `sprite_num`=0
  - `flame_active`=0
  - `done`=0
- `detonate` at edge N: the latched position and `flame_active`=1 are visible after edge N.
- `frame_tick` completing a step at edge N: the new `sprite_num` is visible after edge N.
- The final step end at edge N sets `done`=1 and `flame_active`=0 after edge N. `done` returns to 0 after edge N+1.
- The earliest accepted new `detonate` is at edge N+1.
- Outputs change only on step ends, i.e. during vertical blanking, so each frame is rendered with one consistent sprite.

## Configuration
- `FLAME_HOLD_FLICKER_EN` defined:
  - during HOLD, `sprite_num` alternates 4,3,4,3… at each step end, starting at 4;
  - the HOLD duration is unchanged;
  - SHRINK still starts at 3.
- Undefined: `sprite_num` stays at 4 throughout HOLD.

## Test plan
Unless stated, the bench uses FRAMES_PER_SPRITE=2 and HOLD_STEPS=3.

- **Reset and idle:** reset, then 10 ticks with no `detonate` → outputs stay at (-64, -64, 0), `flame_active`=0, no `done`.
- **Full sequence:** `detonate` with (100, 200), then 22 ticks →
  - `sprite_num` steps 0,1,2,3,4,4,4,3,2,1,0, changing every 2 ticks;
  - `done` pulses once on tick 22;
  - position returns to (-64, -64).
- **Clamping:** `detonate` with (-5, 590) → latched (0, 568). `detonate` with (790, 10) → latched (768, 10).
- **Ignored detonate:** `detonate` with (300, 300) at tick 5 of an explosion started at (100, 100) →
  - position stays (100, 100);
  - `done` only after tick 22;
  - a `detonate` one cycle after `done` is accepted.
- **Mid-run reset:** assert `reset_n` low during HOLD → outputs are at reset values immediately; no `done` pulse.
- **Flicker build:** with `FLAME_HOLD_FLICKER_EN` defined, the full sequence yields 0,1,2,3,4,3,4,3,2,1,0.

Source files
------------

// File: rtl/flame_sequencer.sv
// -----------------------------------------------------------------------------
// flame_sequencer
//
// Sequences a single bomb explosion for the flame sprite renderer. A detonate
// pulse latches the (clamped) bomb position, then the block walks the flame
// sprite index through grow (0..3), hold (4), and shrink (3..0), advancing one
// step every FRAMES_PER_SPRITE frame ticks. While idle the sprite is parked
// off-screen at (-64, -64) so the renderer emits its transparency code.
//
// Optional build macro:
//   FLAME_HOLD_FLICKER_EN - when defined, the sprite alternates 4,3,4,3...
//                           at each step end during HOLD (same duration).
//
// Ports:
//   clk            pixel clock
//   reset_n        asynchronous active-low reset
//   frame_tick     one-cycle pulse per video frame (start of vblank)
//   detonate       one-cycle pulse, starts an explosion when idle
//   bomb_X/bomb_Y  signed sprite top-left position, sampled on detonate
//   flame_centerX  signed X position to the renderer (registered)
//   flame_centerY  signed Y position to the renderer (registered)
//   sprite_num     sprite index 0..4 to the renderer (registered)
//   flame_active   high while an explosion is in progress (registered)
//   done           one-cycle pulse at the end of an explosion (registered)
// -----------------------------------------------------------------------------
module flame_sequencer #(
  parameter int FRAMES_PER_SPRITE = 4,
  parameter int HOLD_STEPS        = 2,
  parameter int HACTIVE           = 800,
  parameter int VACTIVE           = 600
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_tick,
  input  logic               detonate,
  input  logic signed [10:0] bomb_X,
  input  logic signed [10:0] bomb_Y,
  output logic signed [10:0] flame_centerX,
  output logic signed [10:0] flame_centerY,
  output logic        [2:0]  sprite_num,
  output logic               flame_active,
  output logic               done
);

  // Counter widths never drop to zero, even for a one-frame / one-step setup.
  localparam int FW = (FRAMES_PER_SPRITE > 1) ? $clog2(FRAMES_PER_SPRITE) : 1;
  localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SPRITE - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_STEPS - 1);

  // Largest legal top-left coordinate keeps the 32-pixel sprite on screen.
  localparam logic signed [10:0] X_MAX      = 11'(HACTIVE - 32);
  localparam logic signed [10:0] Y_MAX      = 11'(VACTIVE - 32);
  localparam logic signed [10:0] OFF_SCREEN = -11'sd64;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GROW   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_SHRINK = 2'd3
  } state_t;

  // Signed clamp into [0, hi]; negative positions snap to the left/top edge.
  function automatic logic signed [10:0] clamp_pos(
    input logic signed [10:0] value,
    input logic signed [10:0] hi
  );
    logic signed [10:0] result;
    if (value < 11'sd0) begin
      result = 11'sd0;
    end else if (value > hi) begin
      result = hi;
    end else begin
      result = value;
    end
    return result;
  endfunction

  state_t               state_r,     state_s;
  logic [FW-1:0]        frame_cnt_r, frame_cnt_s;
  logic [HW-1:0]        hold_cnt_r,  hold_cnt_s;
  logic [2:0]           sprite_r,    sprite_s;
  logic signed [10:0]   pos_x_r,     pos_x_s;
  logic signed [10:0]   pos_y_r,     pos_y_s;
  logic                 active_r,    active_s;
  logic                 done_r,      done_s;
  logic                 step_end_s;

  // A step ends on the frame tick that completes the frame count; idle ticks never count.
  assign step_end_s = frame_tick && (state_r != ST_IDLE) && (frame_cnt_r == FRAME_LAST);

  // Next-state and next-output logic for the explosion sequencer.
  always_comb begin
    state_s     = state_r;
    frame_cnt_s = frame_cnt_r;
    hold_cnt_s  = hold_cnt_r;
    sprite_s    = sprite_r;
    pos_x_s     = pos_x_r;
    pos_y_s     = pos_y_r;
    active_s    = active_r;
    done_s      = 1'b0;

    // Frame counter runs only while an explosion is in progress.
    if ((state_r != ST_IDLE) && frame_tick) begin
      if (step_end_s) begin
        frame_cnt_s = '0;
      end else begin
        frame_cnt_s = frame_cnt_r + FW'(1);
      end
    end else begin
      frame_cnt_s = frame_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        // A tick arriving with detonate is dropped: the counter starts clean.
        if (detonate) begin
          state_s     = ST_GROW;
          pos_x_s     = clamp_pos(bomb_X, X_MAX);
          pos_y_s     = clamp_pos(bomb_Y, Y_MAX);
          sprite_s    = 3'd0;
          frame_cnt_s = '0;
          hold_cnt_s  = '0;
          active_s    = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_GROW: begin
        if (step_end_s) begin
          sprite_s = sprite_r + 3'd1;
          if (sprite_r == 3'd3) begin
            state_s    = ST_HOLD;
            hold_cnt_s = '0;
          end else begin
            state_s = ST_GROW;
          end
        end else begin
          state_s = ST_GROW;
        end
      end

      ST_HOLD: begin
        if (step_end_s) begin
          if (hold_cnt_r == HOLD_LAST) begin
            // Shrink always begins at 3, whatever the hold phase showed last.
            state_s  = ST_SHRINK;
            sprite_s = 3'd3;
          end else begin
            state_s    = ST_HOLD;
            hold_cnt_s = hold_cnt_r + HW'(1);
`ifdef FLAME_HOLD_FLICKER_EN
            sprite_s   = (sprite_r == 3'd4) ? 3'd3 : 3'd4;
`else
            sprite_s   = 3'd4;
`endif
          end
        end else begin
          state_s = ST_HOLD;
        end
      end

      ST_SHRINK: begin
        if (step_end_s) begin
          if (sprite_r == 3'd0) begin
            // Explosion over: park off-screen and pulse done; detonate this
            // cycle is ignored because the FSM is not idle yet.
            state_s  = ST_IDLE;
            done_s   = 1'b1;
            active_s = 1'b0;
            pos_x_s  = OFF_SCREEN;
            pos_y_s  = OFF_SCREEN;
          end else begin
            state_s  = ST_SHRINK;
            sprite_s = sprite_r - 3'd1;
          end
        end else begin
          state_s = ST_SHRINK;
        end
      end

      default: begin
        state_s     = ST_IDLE;
        frame_cnt_s = '0;
        hold_cnt_s  = '0;
        sprite_s    = 3'd0;
        pos_x_s     = OFF_SCREEN;
        pos_y_s     = OFF_SCREEN;
        active_s    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset parks the sprite off-screen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      frame_cnt_r <= '0;
      hold_cnt_r  <= '0;
      sprite_r    <= 3'd0;
      pos_x_r     <= OFF_SCREEN;
      pos_y_r     <= OFF_SCREEN;
      active_r    <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      frame_cnt_r <= frame_cnt_s;
      hold_cnt_r  <= hold_cnt_s;
      sprite_r    <= sprite_s;
      pos_x_r     <= pos_x_s;
      pos_y_r     <= pos_y_s;
      active_r    <= active_s;
      done_r      <= done_s;
    end
  end

  assign flame_centerX = pos_x_r;
  assign flame_centerY = pos_y_r;
  assign sprite_num    = sprite_r;
  assign flame_active  = active_r;
  assign done          = done_r;

endmodule

// File: tb/tb_flame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_flame_sequencer
//
// Directed, table-driven bench for flame_sequencer with FRAMES_PER_SPRITE=2
// and HOLD_STEPS=3. Each table row is one clock cycle of stimulus with the
// outputs expected after that edge. Hand-written sequences cover clamping,
// ignored detonates and an asynchronous reset during HOLD. Define
// FLAME_HOLD_FLICKER_EN for both bench and RTL to check the flicker build.
// -----------------------------------------------------------------------------
module tb_flame_sequencer;

  logic               clk;
  logic               reset_n;
  logic               frame_tick;
  logic               detonate;
  logic signed [10:0] bomb_X;
  logic signed [10:0] bomb_Y;
  logic signed [10:0] flame_centerX;
  logic signed [10:0] flame_centerY;
  logic [2:0]         sprite_num;
  logic               flame_active;
  logic               done;

  int n_checks = 0;
  int n_fail   = 0;

  flame_sequencer #(
    .FRAMES_PER_SPRITE(2),
    .HOLD_STEPS(3),
    .HACTIVE(800),
    .VACTIVE(600)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .frame_tick(frame_tick),
    .detonate(detonate),
    .bomb_X(bomb_X),
    .bomb_Y(bomb_Y),
    .flame_centerX(flame_centerX),
    .flame_centerY(flame_centerY),
    .sprite_num(sprite_num),
    .flame_active(flame_active),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic det;
    logic tick;
    int   bx;
    int   by;
    int   ex;
    int   ey;
    int   es;
    int   ea;
    int   ed;
  } vec_t;

  vec_t vecs[$];
  int   seq[11];

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int ey,
                           input int es, input int ea, input int ed);
    check({tag, "_x"}, int'(flame_centerX), ex);
    check({tag, "_y"}, int'(flame_centerY), ey);
    check({tag, "_sprite"}, int'(sprite_num), es);
    check({tag, "_active"}, int'(flame_active), ea);
    check({tag, "_done"}, int'(done), ed);
  endtask

  // One clock of stimulus: drive after the falling edge, sample 1ns after the rising edge.
  task automatic cycle(input logic det, input logic tick, input int bx, input int by);
    @(negedge clk);
    detonate   = det;
    frame_tick = tick;
    bomb_X     = 11'(bx);
    bomb_Y     = 11'(by);
    @(posedge clk);
    #1;
    detonate   = 1'b0;
    frame_tick = 1'b0;
  endtask

  function automatic void add(input logic det, input logic tick, input int bx, input int by,
                              input int ex, input int ey, input int es, input int ea, input int ed);
    vec_t v;
    v.det = det; v.tick = tick; v.bx = bx; v.by = by;
    v.ex = ex; v.ey = ey; v.es = es; v.ea = ea; v.ed = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    bit saw_done;

    // Sprite shown during each 2-tick step of one explosion.
`ifdef FLAME_HOLD_FLICKER_EN
    seq = '{0, 1, 2, 3, 4, 3, 4, 3, 2, 1, 0};
`else
    seq = '{0, 1, 2, 3, 4, 4, 4, 3, 2, 1, 0};
`endif

    // Idle: ten frame ticks with no detonate leave everything parked.
    for (int i = 0; i < 10; i++) add(1'b0, 1'b1, 50, 50, -64, -64, 0, 0, 0);
    // Detonate with a coincident tick: position latched, tick not counted.
    add(1'b1, 1'b1, 100, 200, 100, 200, 0, 1, 0);
    // Ticks 1..21; the bomb inputs wander but must not affect the latch.
    for (int k = 1; k < 22; k++) add(1'b0, 1'b1, k * 7, 500 - k, 100, 200, seq[k / 2], 1, 0);
    // Tick 22 ends the explosion; a coincident detonate is ignored.
    add(1'b1, 1'b1, 300, 300, -64, -64, 0, 0, 1);
    // Next cycle: done drops and a detonate is accepted, clamped to (0, 568).
    add(1'b1, 1'b0, -5, 590, 0, 568, 0, 1, 0);
    add(1'b0, 1'b0, 0, 0, 0, 568, 0, 1, 0);

    reset_n    = 1'b0;
    frame_tick = 1'b0;
    detonate   = 1'b0;
    bomb_X     = '0;
    bomb_Y     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", -64, -64, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].det, vecs[i].tick, vecs[i].bx, vecs[i].by);
      check_all($sformatf("row%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].es,
                vecs[i].ea, vecs[i].ed);
    end

    // Second clamp case plus asynchronous reset during HOLD.
    #2;
    reset_n = 1'b0;
    #2;
    check_all("rst1", -64, -64, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1'b1, 1'b0, 790, 10);
    check_all("clamp2", 768, 10, 0, 1, 0);
    for (int k = 1; k <= 9; k++) cycle(1'b0, 1'b1, 0, 0);
    check_all("hold", 768, 10, 4, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_all("midrst", -64, -64, 0, 0, 0);
    @(negedge clk);
    reset_n  = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cycle(1'b0, 1'b1, 0, 0);
      if (done === 1'b1 || flame_active === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", int'(saw_done), 0);

    // Detonate at tick 5 of a running explosion is ignored.
    cycle(1'b1, 1'b0, 100, 100);
    check_all("ign_start", 100, 100, 0, 1, 0);
    for (int k = 1; k <= 22; k++) begin
      cycle(k == 5, 1'b1, 300, 300);
      if (k < 22) check_all($sformatf("ign_t%0d", k), 100, 100, seq[k / 2], 1, 0);
      else        check_all("ign_end", -64, -64, 0, 0, 1);
    end
    cycle(1'b1, 1'b0, 200, 50);
    check_all("ign_redet", 200, 50, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
